// File: rtl/game_round_ctrl_if.sv
// game_round_ctrl_if: tick/start/enable/height inputs and round status outputs of the round controller
interface game_round_ctrl_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int HEIGHT_W    = 9,
  parameter int CNT_W       = 8,
  parameter int SCORE_W     = 16
);
  localparam int ID_W = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  logic                            tick_i;
  logic                            start_i;
  logic [NUM_PLAYERS-1:0]          player_en_i;
  logic [NUM_PLAYERS*HEIGHT_W-1:0] heights_i;
  logic [NUM_PLAYERS-1:0]          in_play_o;
  logic [NUM_PLAYERS-1:0]          alive_o;
  logic                            enable_board_o;
  logic [1:0]                      state_o;
  logic [CNT_W-1:0]                countdown_o;
  logic [SCORE_W-1:0]              score_o;
  logic                            game_over_o;
  logic                            winner_valid_o;
  logic [ID_W-1:0]                 winner_id_o;
  modport master (
    output tick_i, start_i, player_en_i, heights_i,
    input  in_play_o, alive_o, enable_board_o, state_o, countdown_o, score_o,
           game_over_o, winner_valid_o, winner_id_o
  );
  modport slave (
    input  tick_i, start_i, player_en_i, heights_i,
    output in_play_o, alive_o, enable_board_o, state_o, countdown_o, score_o,
           game_over_o, winner_valid_o, winner_id_o
  );
endinterface

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: N-lane round controller (lock players, countdown, death detection, score, winner/draw)
module game_round_ctrl #(
  parameter int NUM_PLAYERS     = 4,
  parameter int HEIGHT_W        = 9,
  parameter int FLOOR_H         = 0,
  parameter int CEIL_H          = 479,
  parameter int COUNTDOWN_TICKS = 240,
  parameter int CNT_W           = 8,
  parameter int SCORE_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  game_round_ctrl_if.slave  bus
);
  localparam int ID_W = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [HEIGHT_W-1:0] FLOOR_V = HEIGHT_W'(FLOOR_H);
  localparam logic [HEIGHT_W-1:0] CEIL_V  = HEIGHT_W'(CEIL_H);
  localparam logic [CNT_W-1:0]    CD_V    = CNT_W'(COUNTDOWN_TICKS);
  typedef enum logic [1:0] {IDLE, COUNTDOWN, RUN, OVER} state_t;
  state_t                 state_q;
  logic                   start_q, enable_board_q, game_over_q, winner_valid_q;
  logic [NUM_PLAYERS-1:0] in_play_q, alive_q, alive_d;
  logic [CNT_W-1:0]       countdown_q;
  logic [SCORE_W-1:0]     score_q;
  logic [ID_W-1:0]        winner_id_q, winner_id_d;
  logic [3:0]             n_d, a_d;
  logic                   start_edge, end_d, solo_d;
  assign start_edge = bus.start_i & ~start_q;
  // Candidate alive vector for this tick; only consumed on a RUN tick
  always_comb begin
    alive_d     = alive_q;
    n_d         = '0;
    a_d         = '0;
    winner_id_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.heights_i[i*HEIGHT_W +: HEIGHT_W] <= FLOOR_V ||
          bus.heights_i[i*HEIGHT_W +: HEIGHT_W] >= CEIL_V) alive_d[i] = 1'b0;
      n_d = n_d + 4'(in_play_q[i]);
      a_d = a_d + 4'(alive_d[i]);
      if (alive_d[i]) winner_id_d = ID_W'(i);
    end
  end
  assign solo_d = n_d >= 4'd2 && a_d == 4'd1;
  assign end_d  = (n_d >= 4'd2 && a_d <= 4'd1) || (n_d == 4'd1 && a_d == 4'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      start_q        <= 1'b1;
      in_play_q      <= '0;
      alive_q        <= '0;
      enable_board_q <= 1'b0;
      countdown_q    <= '0;
      score_q        <= '0;
      game_over_q    <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_id_q    <= '0;
    end else begin
      start_q     <= bus.start_i;
      game_over_q <= 1'b0;
      case (state_q)
        IDLE: if (start_edge && |bus.player_en_i) begin
          state_q        <= COUNTDOWN;
          in_play_q      <= bus.player_en_i;
          alive_q        <= bus.player_en_i;
          countdown_q    <= CD_V;
          score_q        <= '0;
          winner_valid_q <= 1'b0;
          winner_id_q    <= '0;
        end
        COUNTDOWN: if (bus.tick_i) begin
          if (countdown_q == '0) begin
            state_q        <= RUN;
            enable_board_q <= 1'b1;
          end else countdown_q <= countdown_q - 1'b1;
        end
        RUN: if (bus.tick_i) begin
          score_q <= &score_q ? score_q : score_q + 1'b1;
          alive_q <= alive_d;
          if (end_d) begin
            state_q        <= OVER;
            enable_board_q <= 1'b0;
            game_over_q    <= 1'b1;
            winner_valid_q <= solo_d;
            winner_id_q    <= solo_d ? winner_id_d : '0;
          end
        end
        OVER: if (start_edge) begin
          state_q        <= IDLE;
          in_play_q      <= '0;
          alive_q        <= '0;
          countdown_q    <= '0;
          score_q        <= '0;
          winner_valid_q <= 1'b0;
          winner_id_q    <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.state_o        = state_q;
  assign bus.in_play_o      = in_play_q;
  assign bus.alive_o        = alive_q;
  assign bus.enable_board_o = enable_board_q;
  assign bus.countdown_o    = countdown_q;
  assign bus.score_o        = score_q;
  assign bus.game_over_o    = game_over_q;
  assign bus.winner_valid_o = winner_valid_q;
  assign bus.winner_id_o    = winner_id_q;
endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Parametrised round controller for the gravity-flip game. It replaces the fixed 4-player lock/dead logic with N lanes.
- Latches the enabled players on start and runs a countdown before the board is enabled.
- Detects per-player death from height bounds, counts survival ticks as the score, and declares a winner or a draw.
- Sits between the debounced inputs and the per-player gravity/move blocks. Game timing comes from a one-cycle tick strobe, so everything runs on the system clock.

Parameters:
- NUM_PLAYERS, 4, number of player lanes (1..8).
- HEIGHT_W, 9, width of each player height.
- FLOOR_H, 0, height at or below which a player is dead.
- CEIL_H, 479, height at or above which a player is dead.
- COUNTDOWN_TICKS, 240, number of ticks counted in COUNTDOWN before RUN (3 s at 80 Hz).
- CNT_W, 8, width of the countdown counter (must hold COUNTDOWN_TICKS).
- SCORE_W, 16, width of the score counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  game tick strobe, one clk cycle wide (e.g. 80 Hz)
- start  in  1  debounced start level
- player_en  in  NUM_PLAYERS  player enable switches
- heights  in  NUM_PLAYERS*HEIGHT_W  packed heights; player i occupies bits [i*HEIGHT_W +: HEIGHT_W]
- in_play  out  NUM_PLAYERS  players locked into the round
- alive  out  NUM_PLAYERS  players still alive
- enable_board  out  1  line generators run
- state  out  2  0=IDLE 1=COUNTDOWN 2=RUN 3=OVER
- countdown  out  CNT_W  remaining countdown ticks
- score  out  SCORE_W  ticks survived in RUN
- game_over  out  1  one-cycle pulse on the RUN->OVER transition
- winner_valid  out  1  exactly one survivor in a multiplayer round
- winner_id  out  clog2(NUM_PLAYERS) min 1  index of the winner

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - All outputs 0.
  - Internal start_q=1, so a start held through reset does not trigger.
- Start edge: start_edge = start & ~start_q; start_q is registered every clk.
- All state-machine outputs are registered. Updates are visible the cycle after the triggering edge or tick.
- IDLE:
  - On start_edge with player_en != 0: in_play<=player_en, alive<=player_en, countdown<=COUNTDOWN_TICKS, score<=0, winner outputs<=0, go to COUNTDOWN.
  - start_edge with player_en==0 is ignored.
  - tick is ignored.
- COUNTDOWN:
  - On tick: if countdown==0, go to RUN and set enable_board<=1; else countdown<=countdown-1.
  - RUN is therefore entered on the (COUNTDOWN_TICKS+1)th tick.
  - start_edge is ignored.
- RUN, on each tick:
  - score<=score+1, saturating at all-ones.
  - For each i with alive[i]: if heights_i<=FLOOR_H or heights_i>=CEIL_H, clear alive[i].
  - Let n = popcount of in_play and a = popcount of the new alive vector.
  - End condition: (n>=2 and a<=1) or (n==1 and a==0).
  - On end: go to OVER, enable_board<=0, game_over=1 for one cycle.
  - winner_valid<=(n>=2 and a==1); winner_id<=index of the surviving bit, else 0.
  - When all remaining players die on the same tick, the round is a draw: winner_valid=0.
  - Between ticks, heights are not sampled and alive is unchanged.
- OVER:
  - Outputs are held.
  - start_edge returns to IDLE and clears in_play, alive, countdown, score, winner_valid and winner_id.
  - The next start_edge starts a fresh round; a single start_edge never both leaves OVER and starts a round.
- player_en changes outside IDLE are ignored. Heights of players not in in_play are ignored.
- Simultaneous start_edge and tick: only the state-appropriate event is acted on, as listed above.
- rst_n asserted mid-round forces IDLE and all outputs to 0 asynchronously.

Test Plan:
- Reset with start held high, release rst_n, keep start high -> state stays 0 and all outputs 0; drop and re-raise start with player_en=4'b0000 -> still IDLE.
- player_en=4'b1011, start pulse, COUNTDOWN_TICKS=3 -> in_play=4'b1011, alive=4'b1011, state=1; state=2 and enable_board=1 only after the 4th tick; player_en changed to 4'b1111 during the round leaves in_play unchanged.
- RUN, 4 players with heights 200; at tick 10 set h_0=0 and h_2=479; at tick 25 set h_3=480 -> alive=4'b1010 after tick 10; state=3, game_over pulse of 1 cycle, winner_valid=1, winner_id=1, score=25 after tick 25.
- Two players both set to height 0 on the same tick -> alive=0, state=3, winner_valid=0 (draw).
- Single player (player_en=4'b0100) dies at tick 100 of RUN -> state=3, winner_valid=0, score=100; with SCORE_W=4 and death at tick 20 -> score=15 (saturated).
- Assert rst_n low mid-RUN -> all outputs 0 immediately. Separately, start pulse in OVER -> IDLE with cleared outputs, and a further start pulse begins a new countdown.
